// File: rtl/tunable_delay_loop.sv
// ----------------------------------------------------------------------------
// tunable_delay_loop
//
// Purpose:
//   Delays the binary injection signal Is by a tunable number of clock cycles
//   (the tap u) and closes a slow loop around that delay. The phase error is
//   low-pass filtered on the 20 kHz strobe into theta8 (= 8*theta). On the
//   1 kHz tick the tap is either stepped by hand (manual mode, on standby)
//   or nudged by one toward the set point (automatic mode). After every
//   automatic change the loop waits SETTLE_TICKS ticks before judging again.
//
// Ports:
//   clk10MHz    in   1        sole clock, rising edge
//   rst_n       in   1        asynchronous active-low reset
//   Is          in   1        binary injection signal, sampled every clock
//   phase       in   PHASE_W  signed phase measurement
//   pulse20kHz  in   1        filter strobe (level, rising edge used)
//   pulse1kHz   in   1        control tick strobe (level, rising edge used)
//   standby     in   1        manual step request (rising edge used)
//   mode        in   1        0 = manual tuning, 1 = automatic tuning
//   setpoint    in   TW       signed theta8 set point
//   r           out  1        Is delayed by u cycles, optionally inverted
//   u           out  DEPTH_W  tap currently applied to the delay line
//   theta8      out  TW       signed filter state (8*theta)
//   locked      out  1        lock indicator
//
// Optional feature:
//   TUNABLE_DELAY_LOCK_EN  when defined, a lock counter drives 'locked';
//                          otherwise 'locked' is tied low.
// ----------------------------------------------------------------------------
module tunable_delay_loop #(
    parameter int  DEPTH_W      = 8,
    parameter int  PHASE_W      = 8,
    parameter int  U_MIN        = 225,
    parameter int  U_MAX        = 255,
    parameter int  U_INIT       = 239,
    parameter int  DEADBAND     = 8,
    parameter int  SETTLE_TICKS = 4,
    parameter int  LOCK_CNT     = 16,
    parameter int  INVERT_OUT   = 1,
    localparam int TW           = PHASE_W + 3
) (
    input  logic                      clk10MHz,
    input  logic                      rst_n,
    input  logic                      Is,
    input  logic signed [PHASE_W-1:0] phase,
    input  logic                      pulse20kHz,
    input  logic                      pulse1kHz,
    input  logic                      standby,
    input  logic                      mode,
    input  logic signed [TW-1:0]      setpoint,
    output logic                      r,
    output logic [DEPTH_W-1:0]        u,
    output logic signed [TW-1:0]      theta8,
    output logic                      locked
);

    localparam int DEPTH = 1 << DEPTH_W;
    localparam int SW    = $clog2(SETTLE_TICKS + 1);

    localparam logic [DEPTH_W-1:0] U_MIN_V  = DEPTH_W'(U_MIN);
    localparam logic [DEPTH_W-1:0] U_MAX_V  = DEPTH_W'(U_MAX);
    localparam logic [DEPTH_W-1:0] U_INIT_V = DEPTH_W'(U_INIT);
    localparam logic [SW-1:0]      SETTLE_V = SW'(SETTLE_TICKS);
    localparam logic signed [TW:0] DB_POS   = (TW+1)'(DEADBAND);
    localparam logic signed [TW:0] DB_NEG   = -DB_POS;
    localparam logic signed [TW:0] SAT_HI   = (TW+1)'((1 << (TW-1)) - 1);
    localparam logic signed [TW:0] SAT_LO   = (TW+1)'(-(1 << (TW-1)));
    localparam logic               INV      = (INVERT_OUT != 0);

    // Reject parameter sets the delay read-back or the tap range cannot honour.
    if (!(U_MIN >= 2 && U_MIN <= U_INIT && U_INIT <= U_MAX &&
          U_MAX <= DEPTH - 1 && SETTLE_TICKS >= 1 && LOCK_CNT >= 1)) begin : g_bad_params
        $error("tunable_delay_loop: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SETTLE = 2'd1,
        ST_TRACK  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Strobe edge detection
    // ------------------------------------------------------------------------
    logic r_p20_q, r_p1k_q, r_stby_q;
    logic w_p20_ev, w_p1k_ev, w_stby_ev;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk10MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_p20_q  <= 1'b0;
            r_p1k_q  <= 1'b0;
            r_stby_q <= 1'b0;
        end else begin
            r_p20_q  <= pulse20kHz;
            r_p1k_q  <= pulse1kHz;
            r_stby_q <= standby;
        end
    end

    assign w_p20_ev  = pulse20kHz & ~r_p20_q;
    assign w_p1k_ev  = pulse1kHz  & ~r_p1k_q;
    assign w_stby_ev = standby    & ~r_stby_q;

    // ------------------------------------------------------------------------
    // Phase filter: theta8 <= phase + phase_1 + theta8/2 + theta8/4, saturated
    // ------------------------------------------------------------------------
    logic signed [TW-1:0]      r_theta8;
    logic signed [PHASE_W-1:0] r_phase_1;
    logic signed [TW:0]        w_sum;
    logic signed [TW-1:0]      w_theta_sat;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_sum = (TW+1)'(phase) + (TW+1)'(r_phase_1)
              + (TW+1)'(r_theta8 >>> 1) + (TW+1)'(r_theta8 >>> 2);
        w_theta_sat = w_sum[TW-1:0];
        if (w_sum > SAT_HI) begin
            w_theta_sat = SAT_HI[TW-1:0];
        end else if (w_sum < SAT_LO) begin
            w_theta_sat = SAT_LO[TW-1:0];
        end
    end

    always_ff @(posedge clk10MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_theta8  <= '0;
            r_phase_1 <= '0;
        end else if (w_p20_ev) begin
            r_theta8  <= w_theta_sat;
            r_phase_1 <= phase;
        end
    end

    // ------------------------------------------------------------------------
    // Delay line: cell written at edge k is read back at edge k+u
    // ------------------------------------------------------------------------
    logic                r_mem [DEPTH];
    logic [DEPTH_W-1:0]  r_wr_ptr;
    logic [DEPTH_W-1:0]  w_rd_ptr;
    logic [DEPTH_W-1:0]  r_u;
    logic                r_dly;

    assign w_rd_ptr = r_wr_ptr - r_u;

    // NOTE: the cells are reset so r shows a clean history right after reset;
    // this keeps the delay line in flops rather than a RAM macro.
    always_ff @(posedge clk10MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_dly    <= 1'b0;
        end else begin
            r_mem[r_wr_ptr] <= Is;
            r_wr_ptr        <= r_wr_ptr + DEPTH_W'(1);
            r_dly           <= r_mem[w_rd_ptr] ^ INV;
        end
    end

    // ------------------------------------------------------------------------
    // Tuning FSM
    // ------------------------------------------------------------------------
    state_t             r_state, w_state_nxt;
    logic [SW-1:0]      r_settle, w_settle_nxt, w_settle_inc;
    logic [DEPTH_W-1:0] r_u_cmd, w_u_cmd_nxt;
    logic signed [TW:0] w_err;
    logic               w_err_hi, w_err_lo, w_track_tick;

    assign w_err        = (TW+1)'(r_theta8) - (TW+1)'(setpoint);
    assign w_err_hi     = (w_err > DB_POS);
    assign w_err_lo     = (w_err < DB_NEG);
    assign w_track_tick = mode && (r_state == ST_TRACK) && w_p1k_ev;
    assign w_settle_inc = r_settle + SW'(1);

    always_ff @(posedge clk10MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_MANUAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        w_u_cmd_nxt  = r_u_cmd;
        if (!mode) begin
            w_state_nxt  = ST_MANUAL;
            w_settle_nxt = '0;
            if (w_stby_ev) begin
                w_u_cmd_nxt = (r_u_cmd >= U_MAX_V) ? U_MIN_V : r_u_cmd + DEPTH_W'(1);
            end
        end else begin
            unique case (r_state)
                // mode is already 1 here, so this is the 0->1 transition.
                ST_MANUAL: begin
                    w_state_nxt  = ST_SETTLE;
                    w_settle_nxt = '0;
                end
                ST_SETTLE: begin
                    if (w_p1k_ev) begin
                        if (w_settle_inc == SETTLE_V) begin
                            w_state_nxt  = ST_TRACK;
                            w_settle_nxt = '0;
                        end else begin
                            w_settle_nxt = w_settle_inc;
                        end
                    end
                end
                ST_TRACK: begin
                    // A saturated tap stays in TRACK so the loop keeps evaluating.
                    if (w_p1k_ev && w_err_hi && r_u_cmd < U_MAX_V) begin
                        w_u_cmd_nxt  = r_u_cmd + DEPTH_W'(1);
                        w_state_nxt  = ST_SETTLE;
                        w_settle_nxt = '0;
                    end else if (w_p1k_ev && w_err_lo && r_u_cmd > U_MIN_V) begin
                        w_u_cmd_nxt  = r_u_cmd - DEPTH_W'(1);
                        w_state_nxt  = ST_SETTLE;
                        w_settle_nxt = '0;
                    end
                end
                default: w_state_nxt = ST_MANUAL;
            endcase
        end
    end

    // The tick applies the freshly computed command, so a standby edge on the
    // same cycle as a tick takes effect on that tick.
    always_ff @(posedge clk10MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= '0;
            r_u_cmd  <= U_INIT_V;
            r_u      <= U_INIT_V;
        end else begin
            r_settle <= w_settle_nxt;
            r_u_cmd  <= w_u_cmd_nxt;
            if (w_p1k_ev) begin
                r_u <= w_u_cmd_nxt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Lock detection
    // ------------------------------------------------------------------------
`ifdef TUNABLE_DELAY_LOCK_EN
    localparam int          LW     = $clog2(LOCK_CNT + 1);
    localparam logic [LW-1:0] LOCK_V = LW'(LOCK_CNT);
    logic [LW-1:0] r_lock_cnt;

    always_ff @(posedge clk10MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt <= '0;
        end else if (!mode) begin
            r_lock_cnt <= '0;
        end else if (w_track_tick) begin
            if (w_err_hi || w_err_lo) begin
                r_lock_cnt <= '0;
            end else if (r_lock_cnt != LOCK_V) begin
                r_lock_cnt <= r_lock_cnt + LW'(1);
            end
        end
    end

    assign locked = (r_lock_cnt == LOCK_V);
`else
    assign locked = 1'b0;
`endif

    assign r      = r_dly;
    assign u      = r_u;
    assign theta8 = r_theta8;

endmodule

// File: tb/tb_tunable_delay_loop.sv
// ----------------------------------------------------------------------------
// tb_tunable_delay_loop
//
// Self-checking bench for tunable_delay_loop with default parameters.
// Expected values come from a behavioural model: the filter recurrence in
// plain integer arithmetic, a per-edge history of Is for the delay line, and
// closed-form tap sequences for manual and automatic tuning.
// ----------------------------------------------------------------------------
module tb_tunable_delay_loop;

    localparam int TW = 11;
`ifdef TUNABLE_DELAY_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic               clk10MHz   = 1'b0;
    logic               rst_n      = 1'b0;
    logic               Is         = 1'b0;
    logic signed [7:0]  phase      = '0;
    logic               pulse20kHz = 1'b0;
    logic               pulse1kHz  = 1'b0;
    logic               standby    = 1'b0;
    logic               mode       = 1'b0;
    logic signed [TW-1:0] setpoint = '0;
    logic               r;
    logic [7:0]         u;
    logic signed [TW-1:0] theta8;
    logic               locked;

    int total = 0;
    int bad   = 0;

    // Edge history of Is: is_hist[k] holds the value sampled at edge k.
    int   cyc       = 0;
    int   reset_cyc = 0;
    logic is_hist [0:65535];

    tunable_delay_loop dut (
        .clk10MHz   (clk10MHz),
        .rst_n      (rst_n),
        .Is         (Is),
        .phase      (phase),
        .pulse20kHz (pulse20kHz),
        .pulse1kHz  (pulse1kHz),
        .standby    (standby),
        .mode       (mode),
        .setpoint   (setpoint),
        .r          (r),
        .u          (u),
        .theta8     (theta8),
        .locked     (locked)
    );

    always #50 clk10MHz = ~clk10MHz;

    always @(posedge clk10MHz) begin
        is_hist[cyc[15:0]] <= Is;
        cyc                <= cyc + 1;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------------------------------------------------------- model
    function automatic int filt(int th, int p, int p1);
        int s;
        s = p + p1 + (th >>> 1) + (th >>> 2);
        if (s > 1023)  s = 1023;
        if (s < -1024) s = -1024;
        return s;
    endfunction

    // Expected r after edge j with tap tap_v: inverted Is from edge j-tap_v,
    // or inverted 0 when that edge predates the last reset.
    function automatic logic exp_r(int j, int tap_v);
        int idx;
        idx = j - tap_v;
        if (idx < reset_cyc) return 1'b1;
        return ~is_hist[idx];
    endfunction

    function automatic int man_step(int m);
        return (m >= 255) ? 225 : m + 1;
    endfunction

    // ---------------------------------------------------------------- drivers
    task automatic do_reset();
        rst_n = 1'b0; Is = 1'b0; pulse20kHz = 1'b0; pulse1kHz = 1'b0;
        standby = 1'b0; mode = 1'b0; phase = '0; setpoint = '0;
        repeat (2) @(negedge clk10MHz);
        rst_n = 1'b1;
        reset_cyc = cyc;
    endtask

    task automatic tick();
        pulse1kHz = 1'b1;
        @(negedge clk10MHz);
        pulse1kHz = 1'b0;
        @(negedge clk10MHz);
    endtask

    task automatic stby_event(int width);
        standby = 1'b1;
        repeat (width) @(negedge clk10MHz);
        standby = 1'b0;
        @(negedge clk10MHz);
    endtask

    task automatic p20_event(int width);
        pulse20kHz = 1'b1;
        repeat (width) @(negedge clk10MHz);
        pulse20kHz = 1'b0;
        @(negedge clk10MHz);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0; Is = 1'b1; pulse20kHz = 1'b1; pulse1kHz = 1'b1;
        standby = 1'b1; mode = 1'b1; phase = 8'sd50;
        repeat (3) @(negedge clk10MHz);
        total++; if (u !== 8'd239)   begin bad++; $display("FAIL reset_u got=%0d exp=239", u); end
        total++; if (theta8 !== '0)  begin bad++; $display("FAIL reset_theta8 got=%0d exp=0", theta8); end
        total++; if (r !== 1'b0)     begin bad++; $display("FAIL reset_r got=%b exp=0", r); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
        do_reset();
        @(negedge clk10MHz);
        total++; if (r !== 1'b1)     begin bad++; $display("FAIL post_reset_r got=%b exp=1", r); end
        total++; if (u !== 8'd239)   begin bad++; $display("FAIL post_reset_u got=%0d exp=239", u); end
    endtask

    task automatic test_filter_step();
        int th, p1;
        do_reset();
        phase = 8'sd16; th = 0; p1 = 0;
        for (int n = 1; n <= 10; n++) begin
            p20_event($urandom_range(1, 3));
            th = filt(th, 16, p1); p1 = 16;
            total++; if (theta8 !== th) begin bad++; $display("FAIL filter_step[%0d] got=%0d exp=%0d", n, theta8, th); end
            total++; if (int'(theta8) > 128) begin bad++; $display("FAIL filter_overshoot[%0d] got=%0d exp<=128", n, theta8); end
        end
    endtask

    task automatic test_filter_sat();
        int th, p1, pv;
        do_reset();
        th = 0; p1 = 0;
        for (int n = 0; n < 80; n++) begin
            if (n < 25)      phase = 8'sd127;
            else if (n < 50) phase = -8'sd128;
            else             phase = 8'($urandom_range(0, 255));
            pv = int'(phase);
            p20_event($urandom_range(1, 2));
            th = filt(th, pv, p1); p1 = pv;
            total++; if (theta8 !== th) begin bad++; $display("FAIL filter_model[%0d] got=%0d exp=%0d", n, theta8, th); end
            if (n < 25) begin
                total++;
                if (int'(theta8) > 1023 || int'(theta8) < 0) begin
                    bad++; $display("FAIL filter_sat_pos[%0d] got=%0d exp in 0..1023", n, theta8);
                end
            end
        end
    endtask

    task automatic test_delay();
        int lat, k, mu, j;
        do_reset();
        mu = 239;
        repeat (3) @(negedge clk10MHz);
        for (int pass = 0; pass < 2; pass++) begin
            Is = 1'b1; k = cyc;
            @(negedge clk10MHz);
            Is = 1'b0;
            lat = -1;
            for (int i = 0; i < 270; i++) begin
                @(negedge clk10MHz);
                j = cyc - 1;
                total++; if (r !== exp_r(j, mu)) begin bad++; $display("FAIL delay_window[%0d] got=%b exp=%b", j, r, exp_r(j, mu)); end
                if (r == 1'b0 && lat < 0) lat = j - k;
            end
            total++; if (lat !== mu) begin bad++; $display("FAIL delay_latency got=%0d exp=%0d", lat, mu); end
            if (pass == 0) begin
                stby_event(1);
                tick();
                mu = 240;
                total++; if (u !== 8'd240) begin bad++; $display("FAIL delay_tap_step got=%0d exp=240", u); end
                repeat (260) @(negedge clk10MHz);
            end
        end
        // Random Is streams at random taps.
        for (int round = 0; round < 3; round++) begin
            int n;
            n = $urandom_range(1, 30);
            for (int s = 0; s < n; s++) begin
                stby_event(1);
                mu = man_step(mu);
            end
            tick();
            total++; if (u !== mu) begin bad++; $display("FAIL delay_rand_tap got=%0d exp=%0d", u, mu); end
            for (int i = 0; i < 300; i++) begin
                @(negedge clk10MHz);
                j = cyc - 1;
                total++; if (r !== exp_r(j, mu)) begin bad++; $display("FAIL delay_rand[%0d] got=%b exp=%b", j, r, exp_r(j, mu)); end
                Is = 1'($urandom_range(0, 1));
            end
            Is = 1'b0;
        end
    endtask

    task automatic test_manual();
        int mu;
        do_reset();
        mu = 239;
        for (int i = 0; i < 16; i++) begin
            stby_event($urandom_range(1, 3));
            mu = man_step(mu);
        end
        total++; if (u !== 8'd239) begin bad++; $display("FAIL manual_hold_until_tick got=%0d exp=239", u); end
        tick();
        total++; if (u !== 8'd255) begin bad++; $display("FAIL manual_to_max got=%0d exp=255", u); end
        stby_event(1); mu = man_step(mu);
        tick();
        total++; if (u !== 8'd225) begin bad++; $display("FAIL manual_wrap got=%0d exp=225", u); end
        for (int round = 0; round < 5; round++) begin
            int n;
            n = $urandom_range(0, 40);
            for (int s = 0; s < n; s++) begin
                stby_event($urandom_range(1, 2));
                mu = man_step(mu);
            end
            tick();
            total++; if (u !== mu) begin bad++; $display("FAIL manual_rand[%0d] got=%0d exp=%0d", round, u, mu); end
        end
        // Standby edge on the same cycle as the tick.
        standby = 1'b1; pulse1kHz = 1'b1;
        @(negedge clk10MHz);
        standby = 1'b0; pulse1kHz = 1'b0;
        @(negedge clk10MHz);
        mu = man_step(mu);
        total++; if (u !== mu) begin bad++; $display("FAIL manual_coincident got=%0d exp=%0d", u, mu); end
        // A pending command must not survive an asynchronous reset.
        stby_event(1);
        #20 rst_n = 1'b0;
        #1;
        total++; if (u !== 8'd239) begin bad++; $display("FAIL async_reset_u got=%0d exp=239", u); end
        @(negedge clk10MHz);
        rst_n = 1'b1; reset_cyc = cyc;
        tick();
        total++; if (u !== 8'd239) begin bad++; $display("FAIL no_pending_update got=%0d exp=239", u); end
    endtask

    task automatic test_auto_track();
        int e;
        do_reset();
        setpoint = -11'sd40;              // theta8 = 0, so err = +40
        @(negedge clk10MHz);
        mode = 1'b1;
        @(negedge clk10MHz);
        for (int n = 1; n <= 90; n++) begin
            if ($urandom_range(0, 3) == 0) stby_event(1);   // ignored in auto
            repeat ($urandom_range(0, 2)) @(negedge clk10MHz);
            tick();
            e = 239 + n / 5;
            if (e > 255) e = 255;
            total++; if (u !== e) begin bad++; $display("FAIL auto_up[%0d] got=%0d exp=%0d", n, u, e); end
        end
        setpoint = 11'sd40;               // err = -40
        for (int n = 1; n <= 160; n++) begin
            if ($urandom_range(0, 3) == 0) stby_event(1);
            tick();
            e = 255 - (n + 4) / 5;
            if (e < 225) e = 225;
            total++; if (u !== e) begin bad++; $display("FAIL auto_down[%0d] got=%0d exp=%0d", n, u, e); end
        end
    endtask

    task automatic test_lock();
        logic el;
        do_reset();
        setpoint = -11'sd4;               // err = +4, in band
        @(negedge clk10MHz);
        mode = 1'b1;
        @(negedge clk10MHz);
        for (int n = 1; n <= 20; n++) begin
            tick();
            el = LOCK_EN && (n >= 20);
            total++; if (locked !== el) begin bad++; $display("FAIL lock_rise[%0d] got=%b exp=%b", n, locked, el); end
        end
        total++; if (u !== 8'd239) begin bad++; $display("FAIL lock_in_band_u got=%0d exp=239", u); end
        setpoint = -11'sd20;              // err = +20, out of band
        tick();
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_clear got=%b exp=0", locked); end
        total++; if (u !== 8'd240) begin bad++; $display("FAIL lock_out_band_u got=%0d exp=240", u); end
        setpoint = -11'sd4;
        for (int n = 1; n <= 20; n++) begin
            tick();
            el = LOCK_EN && (n >= 20);
            total++; if (locked !== el) begin bad++; $display("FAIL lock_relock[%0d] got=%b exp=%b", n, locked, el); end
        end
        #30 rst_n = 1'b0;
        #1;
        total++; if (u !== 8'd239)  begin bad++; $display("FAIL lock_reset_u got=%0d exp=239", u); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_reset_locked got=%b exp=0", locked); end
        @(negedge clk10MHz);
        rst_n = 1'b1; reset_cyc = cyc;
        @(negedge clk10MHz);
        for (int n = 1; n <= 22; n++) begin
            tick();
            el = LOCK_EN && (n >= 20);
            total++; if (locked !== el) begin bad++; $display("FAIL lock_hold[%0d] got=%b exp=%b", n, locked, el); end
        end
        mode = 1'b0;
        @(negedge clk10MHz);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_mode_clear got=%b exp=0", locked); end
    endtask

    initial begin
        test_reset();
        test_filter_step();
        test_filter_sat();
        test_delay();
        test_manual();
        test_auto_track();
        test_lock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tunable_delay_loop.md
TUNABLE_DELAY_LOOP -- requirements
Module: tunable_delay_loop

Interface
REQ-001 SHALL have parameter DEPTH_W, default 8: delay line depth is 2^DEPTH_W samples, and u is DEPTH_W bits wide.
REQ-002 SHALL have parameter PHASE_W, default 8: width of the signed phase input; the filter width is TW = PHASE_W+3.
REQ-003 SHALL have parameters U_MIN 225, U_MAX 255, U_INIT 239: tap limits and tap reset value, with 2 <= U_MIN <= U_INIT <= U_MAX <= 2^DEPTH_W-1.
REQ-004 SHALL have parameters DEADBAND 8 (theta8 units), SETTLE_TICKS 4 (1 kHz ticks) and LOCK_CNT 16 (in-band evaluations).
REQ-005 SHALL have parameter INVERT_OUT, default 1: when 1, r is the inverted delayed Is.
REQ-006 clk10MHz  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset; asynchronous, active-low.
REQ-008 Is  input  1  binary injection signal, sampled every clock.
REQ-009 phase  input  PHASE_W  signed phase measurement.
REQ-010 pulse20kHz  input  1  filter sample strobe (level; rising edge detected internally).
REQ-011 pulse1kHz  input  1  control tick strobe (level; rising edge detected internally).
REQ-012 standby  input  1  manual step request (rising edge detected internally).
REQ-013 mode  input  1  0 = manual tuning, 1 = automatic tuning.
REQ-014 setpoint  input  TW  signed theta8 set point.
REQ-015 r  output  1  delayed (optionally inverted) Is, registered.
REQ-016 u  output  DEPTH_W  tap currently applied to the delay line.
REQ-017 theta8  output  TW  signed filter state, equal to 8*theta.
REQ-018 locked  output  1  lock indicator.

Function
REQ-019 Each strobe input SHALL be registered once; an edge event is a one-cycle pulse on the cycle when the input is 1 and its registered copy is 0.
REQ-020 On each pulse20kHz event, theta8 SHALL load phase + phase_1 + (theta8>>>1) + (theta8>>>2), where >>> is an arithmetic shift, all operands are sign-extended to TW+1 bits, and the result saturates to the signed TW range; phase_1 SHALL load phase in the same cycle.
REQ-021 The write pointer SHALL increment modulo 2^DEPTH_W every clock and write Is to the addressed cell.
REQ-022 r SHALL equal Is delayed by exactly u clock cycles: the value of Is sampled at edge k appears on r after edge k+u, XORed with INVERT_OUT.
REQ-023 The commanded tap u_cmd SHALL be copied to u only on a pulse1kHz event, so the tap never changes between ticks.
REQ-024 In manual mode, each standby event SHALL increment u_cmd, wrapping from U_MAX to U_MIN.
REQ-025 The tuning FSM SHALL have exactly three states: MANUAL, SETTLE and TRACK.
REQ-026 mode = 0 SHALL force MANUAL; a 0->1 transition of mode SHALL enter SETTLE with the settle counter at 0.
REQ-027 In SETTLE, each pulse1kHz event SHALL increment the settle counter; reaching SETTLE_TICKS SHALL enter TRACK.
REQ-028 In TRACK, each pulse1kHz event SHALL compute err = theta8 - setpoint using TW+1-bit signed arithmetic.
REQ-029 When err > DEADBAND in TRACK, u_cmd SHALL increment, saturating at U_MAX; when err < -DEADBAND, u_cmd SHALL decrement, saturating at U_MIN; otherwise the evaluation is in-band.
REQ-030 Any change of u_cmd in TRACK SHALL return the FSM to SETTLE with the settle counter cleared; a saturated, unchanged u_cmd SHALL remain in TRACK.
REQ-031 In automatic mode, standby SHALL be ignored.
REQ-032 A standby event coinciding with a pulse1kHz event in manual mode SHALL update u_cmd first; the same tick applies the new value.

Reset
REQ-033 While rst_n = 0: theta8, phase_1, the write pointer, all delay cells, r and the strobe registers SHALL be 0; u and u_cmd SHALL be U_INIT; FSM = MANUAL; counters and locked SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL take effect immediately, with no pending tap update surviving it.

Configuration
REQ-035 With TUNABLE_DELAY_LOCK_EN defined, a lock counter SHALL count consecutive in-band TRACK evaluations, saturating at LOCK_CNT; locked = 1 while the count equals LOCK_CNT.
REQ-036 With TUNABLE_DELAY_LOCK_EN defined, the lock counter SHALL clear on an out-of-band evaluation, on leaving TRACK through a mode change, or on reset.
REQ-037 Without TUNABLE_DELAY_LOCK_EN, locked SHALL be tied to 0 and no lock counter SHALL exist.

Verification
REQ-038 Filter step: phase held at 16 with ten 20 kHz events -> theta8 follows the recurrence of REQ-020 exactly and converges to 128 with no overshoot.
REQ-039 Filter saturation: PHASE_W=8, phase held at 127 -> theta8 never exceeds 1023 and never wraps negative.
REQ-040 Delay: u=239, single 1-cycle Is pulse -> r pulses (inverted) exactly 239 cycles later; after a tick that changes u to 240 -> next pulse appears 240 cycles later.
REQ-041 Manual wrap: mode=0, u=255, standby edge, then tick -> u=225.
REQ-042 Auto tracking: setpoint 0, theta8 held at +40 -> u increments once per 5 ticks until it holds at 255; theta8 held at -40 -> u decrements until it holds at 225.
REQ-043 Lock (macro on): theta8 = 4 in TRACK -> locked rises on the 16th in-band tick; theta8 = 20 -> locked clears on the next tick; rst_n pulsed low -> u=239, locked=0 immediately.
